// File: rtl/abs_diff_error_monitor_if.sv
// Bus between the error monitor and its environment: sweep control,
// the vector driven to the candidate, the candidate result and the metrics.
interface abs_diff_error_monitor_if #(
   parameter int W = 2
);
   logic            start;
   logic [2*W-1:0]  dut_in;
   logic [W-1:0]    dut_out;
   logic            busy;
   logic            done;
   logic [W-1:0]    max_err;
   logic [2*W:0]    err_count;
   logic [3*W-1:0]  err_sum;
   logic            pass;

   // Monitor side
   modport master (
      input  start, dut_out,
      output dut_in, busy, done, max_err, err_count, err_sum, pass
   );

   // Environment side: controller plus candidate under test
   modport slave (
      output start, dut_out,
      input  dut_in, busy, done, max_err, err_count, err_sum, pass
   );
endinterface

// File: rtl/abs_diff_error_monitor.sv
// Exhaustive sweep harness for approximate |a-b| candidates: drives every
// input vector, compares each result against the exact value and
// accumulates worst-case error, mismatch count and total absolute error.
module abs_diff_error_monitor #(
   parameter int W  = 2,
   parameter int ET = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   abs_diff_error_monitor_if.master  bus
);
   localparam int IW = 2 * W;
   localparam int CW = 2 * W + 1;
   localparam int SW = 3 * W;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]    state;
   logic [IW-1:0] vec;
   logic          start_ok;

   logic          cap_vld;
   logic [W-1:0]  cap_out;
   logic [IW-1:0] cap_in;

   logic [W-1:0]  max_r;
   logic [CW-1:0] cnt_r;
   logic [SW-1:0] sum_r;

   logic [W-1:0]  op_a;
   logic [W-1:0]  op_b;
   logic [W:0]    diff_w;
   logic [W-1:0]  exact;
   logic [W-1:0]  err;

   assign start_ok = bus.start && ((state == S_IDLE) || (state == S_DONE));

   // Exact |a-b| of the captured vector and the candidate's absolute error
   always_comb begin
      op_a   = cap_in[W-1:0];
      op_b   = cap_in[IW-1:W];
      diff_w = (op_a >= op_b) ? ({1'b0, op_a} - {1'b0, op_b})
                              : ({1'b0, op_b} - {1'b0, op_a});
      exact  = diff_w[W-1:0];
      err    = (cap_out >= exact) ? (cap_out - exact) : (exact - cap_out);
   end

   // Sweep sequencer: state and the vector counter driven to the candidate
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         vec   <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               vec <= '0;
               if (bus.start) state <= S_RUN;
            end
            S_RUN: begin
               if (vec == '1) begin
                  state <= S_DRAIN;
                  vec   <= '0;
               end else begin
                  vec <= vec + 1'b1;
               end
            end
            S_DRAIN: begin
               state <= S_DONE;
               vec   <= '0;
            end
            default: begin
               state <= S_IDLE;
               vec   <= '0;
            end
         endcase
      end
   end

   // Stage 1: capture the candidate result together with its vector
   always_ff @(posedge clk) begin
      if (rst) begin
         cap_vld <= 1'b0;
         cap_out <= '0;
         cap_in  <= '0;
      end else begin
         cap_vld <= (state == S_RUN);
         if (state == S_RUN) begin
            cap_out <= bus.dut_out;
            cap_in  <= vec;
         end
      end
   end

   // Stage 2: accumulate metrics; the accepting start edge clears them
   always_ff @(posedge clk) begin
      if (rst || start_ok) begin
         max_r <= '0;
         cnt_r <= '0;
         sum_r <= '0;
      end else if (cap_vld) begin
         if (err > max_r) max_r <= err;
         cnt_r <= cnt_r + CW'(err != '0);
         sum_r <= sum_r + SW'(err);
      end
   end

   assign bus.dut_in    = vec;
   assign bus.busy      = (state == S_RUN) || (state == S_DRAIN);
   assign bus.done      = (state == S_DONE);
   assign bus.max_err   = max_r;
   assign bus.err_count = cnt_r;
   assign bus.err_sum   = sum_r;
   assign bus.pass      = (state == S_DONE) && (int'(max_r) <= ET);
endmodule

// File: tb/tb_abs_diff_error_monitor.sv
// Directed bench for abs_diff_error_monitor (W=2): two monitors (ET=1 and
// ET=0) watch the same behavioural candidate, selected by a mode variable.
module tb_abs_diff_error_monitor;
   localparam int W = 2;

   localparam int M_EXACT = 0;
   localparam int M_ZERO  = 1;
   localparam int M_CORR5 = 2;
   localparam int M_PLUS1 = 3;
   localparam int M_WORST = 4;

   logic clk;
   logic rst;
   logic start;
   int   mode;
   int   vec_count;
   int   miscompares;

   abs_diff_error_monitor_if #(.W(W)) if1 ();
   abs_diff_error_monitor_if #(.W(W)) if0 ();

   abs_diff_error_monitor #(.W(W), .ET(1)) u_et1 (.clk(clk), .rst(rst), .bus(if1));
   abs_diff_error_monitor #(.W(W), .ET(0)) u_et0 (.clk(clk), .rst(rst), .bus(if0));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural candidates built from the exact |a-b|
   function automatic logic [1:0] cand(input int m, input logic [3:0] v);
      int a, b, e;
      a = int'(v[1:0]);
      b = int'(v[3:2]);
      e = (a >= b) ? a - b : b - a;
      case (m)
         M_ZERO:  return 2'd0;
         M_CORR5: return (v == 4'h5) ? 2'd1 : 2'(e);
         M_PLUS1: return 2'(e + 1);
         M_WORST: return (e < 2) ? 2'd3 : 2'd0;
         default: return 2'(e);
      endcase
   endfunction

   assign if1.start = start;
   assign if0.start = start;
   assign if1.dut_out = cand(mode, if1.dut_in);
   assign if0.dut_out = cand(mode, if0.dut_in);

   task automatic check(input string name, input longint act, input longint exp);
      vec_count++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, " dut_in"},    longint'(if1.dut_in), 0);
      check({tag, " busy"},      longint'(if1.busy), 0);
      check({tag, " done"},      longint'(if1.done), 0);
      check({tag, " max_err"},   longint'(if1.max_err), 0);
      check({tag, " err_count"}, longint'(if1.err_count), 0);
      check({tag, " err_sum"},   longint'(if1.err_sum), 0);
      check({tag, " pass"},      longint'(if1.pass), 0);
      check({tag, " pass_et0"},  longint'(if0.pass), 0);
   endtask

   // Start a sweep and step until done (bounded); start is pulsed again in
   // cycles p1/p2. Every cycle dut_in, busy and the masked pass are audited.
   task automatic run_sweep(input int p1, input int p2, output int lat, output int bad);
      int n;
      longint exp_in;
      logic   exp_busy;
      bad = 0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 1;
      while (!if1.done && n < 40) begin
         exp_in   = (n <= 16) ? longint'(n - 1) : 0;
         exp_busy = (n <= 17);
         if (longint'(if1.dut_in) != exp_in || if1.busy !== exp_busy ||
             if1.pass !== 1'b0 || if0.pass !== 1'b0 || if0.dut_in !== if1.dut_in)
            bad++;
         start = (n == p1) || (n == p2);
         @(posedge clk); #1;
         n++;
      end
      start = 1'b0;
      lat = n;
   endtask

   typedef struct {
      string name;
      int    m;
      int    exp_max;
      int    exp_cnt;
      int    exp_sum;
      int    exp_pass1;
      int    exp_pass0;
   } vec_t;

   task automatic check_metrics(input vec_t v);
      check({v.name, " max_err"},   longint'(if1.max_err),   v.exp_max);
      check({v.name, " err_count"}, longint'(if1.err_count), v.exp_cnt);
      check({v.name, " err_sum"},   longint'(if1.err_sum),   v.exp_sum);
      check({v.name, " pass"},      longint'(if1.pass),      v.exp_pass1);
      check({v.name, " pass_et0"},  longint'(if0.pass),      v.exp_pass0);
      check({v.name, " et0 count"}, longint'(if0.err_count), v.exp_cnt);
   endtask

   vec_t tbl[5];

   initial begin
      int lat, bad, n;
      vec_count   = 0;
      miscompares = 0;
      start = 1'b0;
      mode  = M_EXACT;
      rst   = 1'b1;

      // |a-b| over 4x4: value 0 x4, 1 x6, 2 x4, 3 x2
      tbl[0] = '{"exact", M_EXACT, 0,  0,  0, 1, 1};
      tbl[1] = '{"zero",  M_ZERO,  3, 12, 20, 0, 0};
      tbl[2] = '{"corr5", M_CORR5, 1,  1,  1, 1, 0};
      tbl[3] = '{"plus1", M_PLUS1, 3, 16, 20, 0, 0};
      tbl[4] = '{"worst", M_WORST, 3, 16, 38, 0, 0};

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_reset("reset");

      foreach (tbl[i]) begin
         mode = tbl[i].m;
         run_sweep(0, 0, lat, bad);
         check({tbl[i].name, " latency"}, lat, 18);
         check({tbl[i].name, " dut_in seq"}, bad, 0);
         check({tbl[i].name, " busy in done"}, longint'(if1.busy), 0);
         check_metrics(tbl[i]);
         @(posedge clk); #1;
         check({tbl[i].name, " done hold"}, longint'(if1.done), 1);
         check({tbl[i].name, " count hold"}, longint'(if1.err_count), tbl[i].exp_cnt);
      end

      // Reset at c8 of a sweep discards partial metrics
      mode = M_ZERO;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      check("mid count nonzero", longint'(if1.err_count != 0), 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_reset("midrst");
      run_sweep(0, 0, lat, bad);
      check("rerun latency", lat, 18);
      check_metrics(tbl[1]);

      // start pulses at c5 and in DRAIN are ignored
      mode = M_CORR5;
      run_sweep(5, 17, lat, bad);
      check("ignored start latency", lat, 18);
      check("ignored start seq", bad, 0);
      check_metrics(tbl[2]);

      // start in DONE clears metrics and restarts
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("restart done", longint'(if1.done), 0);
      check("restart busy", longint'(if1.busy), 1);
      check("restart dut_in", longint'(if1.dut_in), 0);
      check("restart max_err", longint'(if1.max_err), 0);
      check("restart err_count", longint'(if1.err_count), 0);
      check("restart err_sum", longint'(if1.err_sum), 0);
      n = 1;
      while (!if1.done && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check("restart latency", n, 18);
      check_metrics(tbl[2]);

      // rst and start together: rst wins
      start = 1'b1;
      rst   = 1'b1;
      @(posedge clk); #1;
      rst   = 1'b0;
      start = 1'b0;
      check_reset("rst+start");

      // start held: DONE lasts exactly one cycle
      mode  = M_ZERO;
      start = 1'b1;
      n = 0;
      while (!if1.done && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check("held latency", n, 18);
      check("held err_count", longint'(if1.err_count), 12);
      @(posedge clk); #1;
      check("held done falls", longint'(if1.done), 0);
      check("held busy again", longint'(if1.busy), 1);
      check("held cleared", longint'(if1.err_count), 0);
      start = 1'b0;
      rst   = 1'b1;
      @(posedge clk); #1;
      rst   = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
      $finish;
   end

   // busy and done must never be high together
   always @(negedge clk) begin
      if (!rst && if1.busy && if1.done) begin
         vec_count++;
         miscompares++;
         $display("FAIL busy_done_excl: got busy=1 done=1, expected not both");
      end
   end
endmodule
